// File: rtl/tmr32_pkg.sv
// tmr32_pkg: shared constants and encodings for the tmr32 timer/capture block
package tmr32_pkg;
  localparam int W = 32;
  typedef enum logic [3:0] {
    CLK_DIV1   = 4'd0,
    CLK_DIV2   = 4'd1,
    CLK_DIV4   = 4'd2,
    CLK_DIV8   = 4'd3,
    CLK_DIV16  = 4'd4,
    CLK_DIV32  = 4'd5,
    CLK_DIV64  = 4'd6,
    CLK_DIV128 = 4'd7,
    CLK_DIV256 = 4'd8,
    CLK_EXT    = 4'd9
  } clk_src_e;
  typedef enum logic [1:0] {
    CP_NONE = 2'd0,
    CP_RISE = 2'd1,
    CP_FALL = 2'd2,
    CP_BOTH = 2'd3
  } cp_event_e;
endpackage

// File: rtl/tmr32_tick_gen.sv
// tmr32_tick_gen: ctr_in synchronizer, edge detect and prescaled tick
//   clk, rst_n : clock, async active-low reset
//   ctr_in     : external async input
//   en         : block enable (holds prescaler at 0 and suppresses ticks when low)
//   clk_src    : tick source select
//   tick       : one-cycle count enable for the counter
//   rise, fall : synchronized ctr_in edges
module tmr32_tick_gen
  import tmr32_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ctr_in,
  input  logic       en,
  input  logic [3:0] clk_src,
  output logic       tick,
  output logic       rise,
  output logic       fall
);
  logic [2:0] sync;
  logic [7:0] psc;
  logic [7:0] mask;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      psc  <= '0;
    end else begin
      sync <= {sync[1:0], ctr_in};
      psc  <= en ? psc + 8'd1 : 8'd0;
    end
  end
  // sync[1:0] is the 2-FF synchronizer, sync[2] the edge-detect register
  always_comb begin
    rise = sync[1] & ~sync[2];
    fall = ~sync[1] & sync[2];
    mask = 8'((9'd1 << clk_src) - 9'd1);
    tick = en & (clk_src == CLK_DIV1   ? 1'b1 :
                 clk_src <= CLK_DIV256 ? &(psc | ~mask) :
                 clk_src == CLK_EXT    ? rise : 1'b0);
  end
endmodule

// File: rtl/tmr32_ccp.sv
// tmr32_ccp: 32-bit timer with prescaler, one-shot/periodic up/down count, PWM, capture, match
//   clk, rst_n          : clock, async active-low reset
//   ctr_in              : external input (ext tick / capture source)
//   en, tmr_en          : block enable, timer run enable
//   clk_src, up, one_shot, period : tick source, direction, mode, reload value
//   pwm_en, pwm_cmp     : PWM enable and compare value
//   cp_en, cp_event     : capture enable and edge select
//   ctr_match           : match value
//   tmr, cp_count       : counter value, last captured interval
//   to_flag, cp_flag, match_flag : one-cycle event pulses
//   pwm_out             : PWM waveform
module tmr32_ccp
  import tmr32_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ctr_in,
  input  logic         en,
  input  logic         tmr_en,
  input  logic [3:0]   clk_src,
  input  logic         up,
  input  logic         one_shot,
  input  logic [W-1:0] period,
  input  logic         pwm_en,
  input  logic [W-1:0] pwm_cmp,
  input  logic         cp_en,
  input  logic [1:0]   cp_event,
  input  logic [W-1:0] ctr_match,
  output logic [W-1:0] tmr,
  output logic [W-1:0] cp_count,
  output logic         to_flag,
  output logic         cp_flag,
  output logic         match_flag,
  output logic         pwm_out
);
  logic         tick, rise, fall, done, timeout, cap;
  logic [W-1:0] nxt, interval;
  tmr32_tick_gen u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctr_in  (ctr_in),
    .en      (en),
    .clk_src (clk_src),
    .tick    (tick),
    .rise    (rise),
    .fall    (fall)
  );
  always_comb begin
    timeout = up ? (tmr >= period) : (tmr == '0);
    nxt     = timeout ? (up ? '0 : period) : (up ? tmr + 1'b1 : tmr - 1'b1);
    cap     = cp_en & ((rise & (cp_event == CP_RISE || cp_event == CP_BOTH)) |
                       (fall & (cp_event == CP_FALL || cp_event == CP_BOTH)));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr        <= '0;
      cp_count   <= '0;
      interval   <= '0;
      done       <= 1'b0;
      to_flag    <= 1'b0;
      cp_flag    <= 1'b0;
      match_flag <= 1'b0;
      pwm_out    <= 1'b0;
    end else begin
      to_flag    <= 1'b0;
      cp_flag    <= 1'b0;
      match_flag <= 1'b0;
      pwm_out    <= pwm_en & tmr_en & en & (tmr < pwm_cmp);
      if (!en) begin
        interval <= '0;
      end else begin
        if (!tmr_en) begin
          tmr  <= up ? '0 : period;
          done <= 1'b0;
        end else if (tick && !done) begin
          tmr        <= nxt;
          to_flag    <= timeout;
          match_flag <= nxt == ctr_match;
          done       <= one_shot & timeout;
        end
        // the capture cycle itself is the first cycle of the next interval
        if (!cp_en) begin
          interval <= '0;
        end else if (cap) begin
          cp_count <= interval;
          interval <= W'(1);
          cp_flag  <= 1'b1;
        end else if (interval != '1) begin
          interval <= interval + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tmr32_ccp.sv
// tb_tmr32_ccp: directed self-checking bench for tmr32_ccp
module tb_tmr32_ccp;
  logic        clk = 1'b0;
  logic        rst_n, ctr_in, en, tmr_en, up, one_shot, pwm_en, cp_en;
  logic [3:0]  clk_src;
  logic [1:0]  cp_event;
  logic [31:0] period, pwm_cmp, ctr_match, tmr, cp_count;
  logic        to_flag, cp_flag, match_flag, pwm_out;
  int          n_cmp = 0;
  int          n_bad = 0;
  tmr32_ccp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctr_in     (ctr_in),
    .en         (en),
    .tmr_en     (tmr_en),
    .clk_src    (clk_src),
    .up         (up),
    .one_shot   (one_shot),
    .period     (period),
    .pwm_en     (pwm_en),
    .pwm_cmp    (pwm_cmp),
    .cp_en      (cp_en),
    .cp_event   (cp_event),
    .ctr_match  (ctr_match),
    .tmr        (tmr),
    .cp_count   (cp_count),
    .to_flag    (to_flag),
    .cp_flag    (cp_flag),
    .match_flag (match_flag),
    .pwm_out    (pwm_out)
  );
  always #50 clk = ~clk;
  task automatic start(input logic u, input logic os, input logic [3:0] src, input logic [31:0] per);
    @(negedge clk);
    en = 1'b0; tmr_en = 1'b0; up = u; one_shot = os; clk_src = src; period = per;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    tmr_en = 1'b1;
  endtask
  task automatic test_reset;
    n_cmp++;
    if ({tmr, cp_count, to_flag, cp_flag, match_flag, pwm_out} !== 68'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: tmr=%0h cp_count=%0h flags=%b%b%b pwm=%b want all 0", tmr, cp_count, to_flag, cp_flag, match_flag, pwm_out);
    end
  endtask
  task automatic test_one_shot;
    int at, n;
    at = 0; n = 0;
    start(1'b0, 1'b1, 4'd1, 32'd20);
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (to_flag) begin n++; if (at == 0) at = i; end
    end
    n_cmp++; if (at !== 41) begin n_bad++; $display("FAIL oneshot_latency: got %0d want 41", at); end
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL oneshot_count: got %0d want 1", n); end
    n_cmp++; if (tmr !== 32'd20) begin n_bad++; $display("FAIL oneshot_frozen: got %0d want 20", tmr); end
    tmr_en = 1'b0;
  endtask
  task automatic test_periodic;
    int p [3];
    int k;
    logic [31:0] prev;
    k = 0; prev = '0; p = '{0, 0, 0};
    start(1'b1, 1'b0, 4'd1, 32'd10);
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (to_flag) begin
        if (k < 3) p[k] = i;
        k++;
        n_cmp++;
        if (prev !== 32'd10 || tmr !== 32'd0) begin n_bad++; $display("FAIL periodic_wrap: %0d->%0d want 10->0", prev, tmr); end
      end
      prev = tmr;
    end
    n_cmp++; if (p[0] !== 21) begin n_bad++; $display("FAIL periodic_first: got %0d want 21", p[0]); end
    n_cmp++; if (p[1] - p[0] !== 22 || p[2] - p[1] !== 22) begin n_bad++; $display("FAIL periodic_spacing: got %0d,%0d want 22,22", p[1] - p[0], p[2] - p[1]); end
    tmr_en = 1'b0;
  endtask
  task automatic test_pwm;
    int hi, rises;
    logic last;
    pwm_en = 1'b1; pwm_cmp = 32'd5;
    start(1'b1, 1'b0, 4'd1, 32'd10);
    repeat (5) @(negedge clk);
    hi = 0; rises = 0; last = pwm_out;
    repeat (66) begin
      @(negedge clk);
      if (pwm_out) hi++;
      if (pwm_out && !last) rises++;
      last = pwm_out;
    end
    n_cmp++; if (hi !== 30) begin n_bad++; $display("FAIL pwm_duty: high %0d clks want 30", hi); end
    n_cmp++; if (rises !== 3) begin n_bad++; $display("FAIL pwm_pulses: got %0d want 3", rises); end
    pwm_cmp = 32'd0;
    repeat (2) @(negedge clk);
    hi = 0;
    repeat (22) begin @(negedge clk); if (pwm_out) hi++; end
    n_cmp++; if (hi !== 0) begin n_bad++; $display("FAIL pwm_cmp0: high %0d want 0", hi); end
    pwm_cmp = 32'd11;
    repeat (2) @(negedge clk);
    hi = 0;
    repeat (22) begin @(negedge clk); if (pwm_out) hi++; end
    n_cmp++; if (hi !== 22) begin n_bad++; $display("FAIL pwm_cmp_gt_period: high %0d want 22", hi); end
    pwm_en = 1'b0; tmr_en = 1'b0;
  endtask
  task automatic test_period_zero;
    int n, nz;
    n = 0; nz = 0;
    start(1'b1, 1'b0, 4'd0, 32'd0);
    repeat (10) begin
      @(negedge clk);
      if (to_flag) n++;
      if (tmr !== 32'd0) nz++;
    end
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL period0_flags: got %0d want 10", n); end
    n_cmp++; if (nz !== 0) begin n_bad++; $display("FAIL period0_tmr: nonzero %0d times want 0", nz); end
    tmr_en = 1'b0;
  endtask
  task automatic test_ext_match;
    int m_at, m_n, t_at, t_n;
    m_at = 0; m_n = 0; t_at = 0; t_n = 0;
    ctr_in = 1'b0; ctr_match = 32'd17;
    start(1'b1, 1'b0, 4'd9, 32'd30);
    for (int r = 1; r <= 35; r++) begin
      ctr_in = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (c == 2) ctr_in = 1'b0;
        if (match_flag) begin m_n++; m_at = r; end
        if (to_flag) begin t_n++; t_at = r; end
      end
    end
    n_cmp++; if (m_at !== 17 || m_n !== 1) begin n_bad++; $display("FAIL ext_match: rise %0d count %0d want rise 17 count 1", m_at, m_n); end
    n_cmp++; if (t_at !== 31 || t_n !== 1) begin n_bad++; $display("FAIL ext_timeout: rise %0d count %0d want rise 31 count 1", t_at, t_n); end
    n_cmp++; if (tmr !== 32'd4) begin n_bad++; $display("FAIL ext_tmr: got %0d want 4", tmr); end
    tmr_en = 1'b0; ctr_match = 32'hffff_ffff;
  endtask
  task automatic run_toggles(output int flags);
    flags = 0;
    repeat (8) begin
      ctr_in = ~ctr_in;
      repeat (9) begin @(negedge clk); if (cp_flag) flags++; end
    end
  endtask
  task automatic test_capture;
    int f;
    ctr_in = 1'b0; cp_en = 1'b1; cp_event = 2'd1;
    repeat (5) @(negedge clk);
    run_toggles(f);
    n_cmp++; if (f !== 4) begin n_bad++; $display("FAIL cap_rise_flags: got %0d want 4", f); end
    n_cmp++; if (cp_count !== 32'd18) begin n_bad++; $display("FAIL cap_rise_count: got %0d want 18", cp_count); end
    cp_event = 2'd3;
    run_toggles(f);
    n_cmp++; if (f !== 8) begin n_bad++; $display("FAIL cap_both_flags: got %0d want 8", f); end
    n_cmp++; if (cp_count !== 32'd9) begin n_bad++; $display("FAIL cap_both_count: got %0d want 9", cp_count); end
    cp_event = 2'd2;
    run_toggles(f);
    n_cmp++; if (f !== 4 || cp_count !== 32'd18) begin n_bad++; $display("FAIL cap_fall: flags %0d count %0d want 4 / 18", f, cp_count); end
    cp_event = 2'd0;
    run_toggles(f);
    n_cmp++; if (f !== 0 || cp_count !== 32'd18) begin n_bad++; $display("FAIL cap_none: flags %0d count %0d want 0 / 18", f, cp_count); end
    cp_en = 1'b0;
  endtask
  task automatic test_en_hold;
    int bad_t, fl;
    logic [31:0] t;
    bad_t = 0; fl = 0;
    pwm_en = 1'b1; pwm_cmp = 32'hffff_ffff;
    start(1'b1, 1'b0, 4'd0, 32'd1000);
    repeat (10) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    t = tmr;
    repeat (20) begin
      @(negedge clk);
      if (tmr !== t) bad_t++;
      if (to_flag | match_flag | cp_flag | pwm_out) fl++;
    end
    n_cmp++; if (t !== 32'd10 || bad_t !== 0) begin n_bad++; $display("FAIL en_hold_tmr: held %0d changed %0d times want 10 / 0", t, bad_t); end
    n_cmp++; if (fl !== 0) begin n_bad++; $display("FAIL en_hold_flags: active %0d times want 0", fl); end
    pwm_en = 1'b0; tmr_en = 1'b0;
  endtask
  task automatic test_async_reset;
    start(1'b1, 1'b0, 4'd0, 32'd1000);
    pwm_en = 1'b1; pwm_cmp = 32'hffff_ffff;
    repeat (10) @(negedge clk);
    n_cmp++; if (tmr !== 32'd10 || pwm_out !== 1'b1) begin n_bad++; $display("FAIL pre_reset: tmr %0d pwm %b want 10 / 1", tmr, pwm_out); end
    #20 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tmr, cp_count, to_flag, cp_flag, match_flag, pwm_out} !== 68'd0) begin
      n_bad++;
      $display("FAIL async_reset: tmr=%0h cp_count=%0h flags=%b%b%b pwm=%b want all 0", tmr, cp_count, to_flag, cp_flag, match_flag, pwm_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pwm_en = 1'b0; tmr_en = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; ctr_in = 1'b0; en = 1'b0; tmr_en = 1'b0; clk_src = 4'd1; up = 1'b1;
    one_shot = 1'b0; period = '0; pwm_en = 1'b0; pwm_cmp = '0; cp_en = 1'b0;
    cp_event = 2'd0; ctr_match = 32'hffff_ffff;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_one_shot;
    test_periodic;
    test_pwm;
    test_period_zero;
    test_ext_match;
    test_capture;
    test_en_hold;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
